bpsk_demod: RTL

Coherent BPSK demodulator. It sits directly downstream of the BPSK modulator and consumes its 8-bit signed sample stream. Each sample is multiplied by a local carrier reference, the products are integrated over one symbol, and the sign of the sum gives the recovered bit. A correlation-magnitude lock detector reports when the link is healthy.

---
 rtl/bpsk_pkg.sv | 45 ++++
 rtl/bpsk_carrier_ref.sv | 28 ++
 rtl/bpsk_demod.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: carrier table, bit mapping and FSM state types.
// The modulator imports the same package so both ends use one carrier table.
package bpsk_pkg;

  localparam int SAMPLE_W          = 8;
  localparam int SAMPLES_PER_CYCLE = 20;
  localparam int PHASE_W           = $clog2(SAMPLES_PER_CYCLE);
  localparam int PROD_W            = 2 * SAMPLE_W;

  // Bit value sent as +carrier; the other bit value is sent as -carrier.
  localparam logic BIT_POS_CARRIER = 1'b0;

  typedef enum logic { ST_IDLE, ST_RUN } main_state_e;
  typedef enum logic { ST_UNLOCKED, ST_LOCKED } lock_state_e;

  // One carrier period: round(127 * sin(2*pi*k/20)).
  function automatic logic signed [SAMPLE_W-1:0] carrier_lut(input logic [PHASE_W-1:0] phase);
    logic signed [SAMPLE_W-1:0] v;
    case (phase)
      5'd0:    v = 8'sd0;
      5'd1:    v = 8'sd39;
      5'd2:    v = 8'sd75;
      5'd3:    v = 8'sd103;
      5'd4:    v = 8'sd121;
      5'd5:    v = 8'sd127;
      5'd6:    v = 8'sd121;
      5'd7:    v = 8'sd103;
      5'd8:    v = 8'sd75;
      5'd9:    v = 8'sd39;
      5'd10:   v = 8'sd0;
      5'd11:   v = -8'sd39;
      5'd12:   v = -8'sd75;
      5'd13:   v = -8'sd103;
      5'd14:   v = -8'sd121;
      5'd15:   v = -8'sd127;
      5'd16:   v = -8'sd121;
      5'd17:   v = -8'sd103;
      5'd18:   v = -8'sd75;
      5'd19:   v = -8'sd39;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bpsk_carrier_ref.sv
// Local carrier reference: phase counter that steps once per accepted sample
// and a lookup into the shared carrier table.
module bpsk_carrier_ref
  import bpsk_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       advance,
  output logic signed [SAMPLE_W-1:0] carrier
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (advance) begin
      phase_d = (phase_q == PHASE_W'(SAMPLES_PER_CYCLE - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign carrier = carrier_lut(phase_q);

endmodule

// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: multiply by the local carrier, integrate over one
// symbol, slice on the sign, and track link health with a lock FSM.
//
// state       | meaning
// ST_IDLE     | out of reset, no sample accepted yet
// ST_RUN      | correlating; left only on reset
// ST_UNLOCKED | counting consecutive good symbols toward lock
// ST_LOCKED   | counting consecutive bad symbols toward unlock
module bpsk_demod
  import bpsk_pkg::SAMPLE_W, bpsk_pkg::PROD_W, bpsk_pkg::BIT_POS_CARRIER,
         bpsk_pkg::main_state_e, bpsk_pkg::lock_state_e,
         bpsk_pkg::ST_IDLE, bpsk_pkg::ST_RUN, bpsk_pkg::ST_UNLOCKED, bpsk_pkg::ST_LOCKED;
#(
  parameter int SAMPLES_PER_CYCLE = 20,
  parameter int SAMPLES_PER_BIT   = 60,
  parameter int ACC_W             = 24,
  parameter int LOCK_THRESH       = 100000,
  parameter int LOCK_SYMS         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic signed [ACC_W-1:0]    corr_out,
  output logic                       locked
);

  localparam int CNT_W  = $clog2(SAMPLES_PER_BIT);
  localparam int LCNT_W = $clog2(LOCK_SYMS + 1);

  if (ACC_W < 16 + $clog2(SAMPLES_PER_BIT)) begin : g_acc_w_chk
    $error("bpsk_demod: ACC_W too narrow for one symbol of full-scale products");
  end
  if (SAMPLES_PER_CYCLE != bpsk_pkg::SAMPLES_PER_CYCLE ||
      SAMPLES_PER_BIT % SAMPLES_PER_CYCLE != 0) begin : g_len_chk
    $error("bpsk_demod: symbol length must be whole carrier periods of the shared table");
  end

  logic signed [SAMPLE_W-1:0] carrier;
  logic signed [PROD_W-1:0]   samp_x, car_x, prod;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W:0]      sum_x;
  logic [ACC_W:0]             mag;
  logic                       last, dump, good;

  main_state_e             state_q, state_d;
  lock_state_e             lock_state_q, lock_state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, corr_q, corr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [LCNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                    bit_q, bit_d, valid_q, valid_d, locked_q, locked_d;

  bpsk_carrier_ref u_carrier (
    .clk     (clk),
    .rst     (rst),
    .advance (in_valid),
    .carrier (carrier)
  );

  always_comb begin
    samp_x = PROD_W'(in_sample);
    car_x  = PROD_W'(carrier);
    prod   = samp_x * car_x;
    sum    = acc_q + ACC_W'(prod);
    // One extra bit so the most-negative sum still has a representable magnitude.
    sum_x  = (ACC_W+1)'(sum);
    mag    = sum_x[ACC_W] ? -sum_x : sum_x;
    good   = mag >= (ACC_W+1)'(LOCK_THRESH);
    last   = count_q == CNT_W'(SAMPLES_PER_BIT - 1);
    dump   = in_valid && last;

    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    corr_d       = corr_q;
    bit_d        = bit_q;
    valid_d      = 1'b0;
    lock_state_d = lock_state_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;

    if (in_valid) begin
      state_d = ST_RUN;
      acc_d   = last ? '0 : sum;
      count_d = last ? '0 : count_q + 1'b1;
    end

    if (dump) begin
      corr_d  = sum;
      bit_d   = sum[ACC_W-1] ? ~BIT_POS_CARRIER : BIT_POS_CARRIER;
      valid_d = 1'b1;
      // Progress is a good symbol while unlocked, or a bad one while locked.
      if (good == (lock_state_q == ST_UNLOCKED)) begin
        if (lock_cnt_q == LCNT_W'(LOCK_SYMS - 1)) begin
          lock_cnt_d   = '0;
          lock_state_d = (lock_state_q == ST_UNLOCKED) ? ST_LOCKED : ST_UNLOCKED;
          locked_d     = (lock_state_q == ST_UNLOCKED);
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end else begin
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      corr_q       <= '0;
      bit_q        <= 1'b0;
      valid_q      <= 1'b0;
      lock_state_q <= ST_UNLOCKED;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      corr_q       <= corr_d;
      bit_q        <= bit_d;
      valid_q      <= valid_d;
      lock_state_q <= lock_state_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = valid_q;
  assign corr_out  = corr_q;
  assign locked    = locked_q;

endmodule
